dct_sequencer: RTL and testbench
================================

DCT_SEQUENCER -- requirements
Module: dct_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 32: elements per DCT frame.
REQ-002 Parameter N_COEF, default 13: cycles each element is held; equals the number of DCT output coefficients.
REQ-003 Parameter I_BW, default 8: element width.
REQ-004 Port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port en_i, input, 1: enable; low flushes the block to IDLE.
REQ-007 Port data_i, input, I_BW: upstream element.
REQ-008 Port valid_i, input, 1: data_i is valid this cycle; there is no backpressure.
REQ-009 Port last_i, input, 1: marks the final element of an utterance; sampled with that element.
REQ-010 Port dct_data_o, output, I_BW: element presented to the DCT.
REQ-011 Port dct_valid_o, output, 1: valid to the DCT.
REQ-012 Port dct_last_o, output, 1: last to the DCT.
REQ-013 Port dct_en_o, output, 1: enable to the DCT; equals en_i.
REQ-014 Port overflow_o, output, 1: one-cycle pulse when an element is dropped.

Function
REQ-015 The block SHALL contain two FRAME_LEN x I_BW banks used ping-pong: one bank fills while the other replays.
REQ-016 Fill side SHALL write each valid_i element to the fill bank at wr_ptr, then increment wr_ptr.
REQ-017 When wr_ptr reaches FRAME_LEN-1 and an element is written, the fill side SHALL mark the bank full, store the frame's last flag (OR of last_i over the frame), reset wr_ptr to 0 and swap fill banks.
REQ-018 If valid_i arrives while both banks are full, the element SHALL be dropped, overflow_o SHALL pulse for that cycle, and wr_ptr SHALL stay unchanged.
REQ-019 The replay FSM SHALL have three states: IDLE, REPLAY, GAP.
REQ-020 IDLE -> REPLAY on the cycle after any bank becomes full; elem_cnt=0, coef_cnt=0.
REQ-021 In REPLAY, dct_valid_o SHALL be 1 and dct_data_o SHALL equal bank[elem_cnt], held constant for exactly N_COEF consecutive cycles.
REQ-022 In REPLAY, coef_cnt SHALL wrap at N_COEF-1 and then increment elem_cnt.
REQ-023 A frame SHALL occupy exactly FRAME_LEN*N_COEF cycles (416 at defaults) of continuous dct_valid_o.
REQ-024 dct_last_o SHALL be 1 only during the final N_COEF cycles of a frame whose stored last flag is set.
REQ-025 REPLAY -> GAP after the final cycle of a frame; the replayed bank SHALL be freed on that transition.
REQ-026 GAP SHALL last exactly one cycle with dct_valid_o=0, so the DCT clears its accumulators; consecutive frames are never back-to-back.
REQ-027 GAP -> REPLAY if the other bank is full, else GAP -> IDLE.
REQ-028 dct_data_o, dct_valid_o and dct_last_o SHALL be registered outputs; dct_data_o=0 whenever dct_valid_o=0.
REQ-029 A bank filling and a bank freeing in the same cycle SHALL both take effect; this SHALL not cause an overflow.
REQ-030 When en_i=0, the block SHALL apply the same clearing as reset, except dct_en_o follows en_i.

Reset
REQ-031 With rst_i=1, the block SHALL clear the FSM to IDLE, both bank-full flags, wr_ptr, elem_cnt and coef_cnt.
REQ-032 With rst_i=1, dct_valid_o, dct_last_o, dct_data_o and overflow_o SHALL be 0.
REQ-033 Bank contents SHALL not be reset.
REQ-034 Reset mid-REPLAY SHALL abandon the frame; dct_valid_o SHALL be 0 on the next cycle.

Configuration
REQ-035 Macro DCT_SEQ_OVERFLOW_CNT_EN defined: the block SHALL add port overflow_cnt_o, output, 8 bits, a saturating count (stops at 255) of dropped elements, cleared by reset or en_i=0.
REQ-036 Macro DCT_SEQ_OVERFLOW_CNT_EN undefined: the port and counter SHALL be absent; overflow_o is unaffected.

Structure
REQ-037 Package dct_pkg SHALL hold FRAME_LEN, N_COEF, I_BW, and the FSM state enum {IDLE, REPLAY, GAP}.
REQ-038 The ping-pong storage, with full flags and write pointer, SHALL be sub-module dct_frame_buffer; the FSM stays in dct_sequencer.

Verification
REQ-039 Scenario: 32 valid elements 0..31 in consecutive cycles -> dct_valid_o rises 1 cycle after the 32nd write; each value is held 13 cycles; 416 valid cycles; then 1 invalid cycle.
REQ-040 Scenario: two frames back-to-back (64 cycles of valid_i) -> frame 2 replay starts exactly 1 GAP cycle after frame 1 ends; no overflow.
REQ-041 Scenario: 96 consecutive elements -> elements 65..96 are dropped; overflow_o pulses 32 times; overflow_cnt_o=32 when the macro is defined.
REQ-042 Scenario: last_i with element 31 of frame 1 -> dct_last_o high for cycles 404..416 of that replay only.
REQ-043 Scenario: rst_i at cycle 200 of a replay -> dct_valid_o=0 on the next cycle; a new 32-element frame then replays normally.
REQ-044 Scenario: en_i=0 for 1 cycle mid-fill at wr_ptr=10 -> wr_ptr returns to 0; the next 32 elements form one frame.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the DCT front-end sequencer.
package dct_pkg;

  localparam int unsigned FRAME_LEN = 32;
  localparam int unsigned N_COEF    = 13;
  localparam int unsigned I_BW      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Counter width that stays legal for a depth of one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dct_sequencer_if.sv
// Upstream element stream and DCT-side outputs of dct_sequencer.
interface dct_sequencer_if #(
  parameter int unsigned I_BW = dct_pkg::I_BW
) ();

  logic            en_i;
  logic [I_BW-1:0] data_i;
  logic            valid_i;
  logic            last_i;
  logic [I_BW-1:0] dct_data_o;
  logic            dct_valid_o;
  logic            dct_last_o;
  logic            dct_en_o;
  logic            overflow_o;

  modport master (
    output en_i, data_i, valid_i, last_i,
    input  dct_data_o, dct_valid_o, dct_last_o, dct_en_o, overflow_o
  );

  modport slave (
    input  en_i, data_i, valid_i, last_i,
    output dct_data_o, dct_valid_o, dct_last_o, dct_en_o, overflow_o
  );

endinterface

// File: rtl/dct_frame_buffer.sv
// Ping-pong frame storage: two banks, full flags, per-bank last flag and write pointer.
module dct_frame_buffer
  import dct_pkg::*;
#(
  parameter int unsigned FRAME_LEN = dct_pkg::FRAME_LEN,
  parameter int unsigned I_BW      = dct_pkg::I_BW,
  localparam int unsigned AW       = cnt_w(FRAME_LEN)
) (
  input  logic            i_clk,
  input  logic            i_clr,
  input  logic            i_valid,
  input  logic [I_BW-1:0] i_data,
  input  logic            i_last,
  input  logic            i_free,
  input  logic [AW-1:0]   i_rd_addr,
  output logic            o_rd_full,
  output logic            o_rd_last,
  output logic [I_BW-1:0] o_rd_data,
  output logic            o_overflow
);

  logic [I_BW-1:0] r_bank [2][FRAME_LEN];
  logic [1:0]      r_full;
  logic [1:0]      r_last;
  logic            r_fill_sel;
  logic            r_rd_sel;
  logic [AW-1:0]   r_wr_ptr;
  logic            r_last_acc;

  logic       w_fill_freed;
  logic       w_drop;
  logic       w_wr;
  logic       w_wrap;
  logic [1:0] w_set;
  logic [1:0] w_rel;

  // A bank released this cycle may accept the incoming element.
  assign w_fill_freed = i_free && (r_rd_sel == r_fill_sel);
  assign w_drop       = !i_clr && i_valid && r_full[r_fill_sel] && !w_fill_freed;
  assign w_wr         = !i_clr && i_valid && !w_drop;
  assign w_wrap       = w_wr && (r_wr_ptr == AW'(FRAME_LEN - 1));
  assign w_set        = w_wrap ? (2'b01 << r_fill_sel) : 2'b00;
  assign w_rel        = i_free ? (2'b01 << r_rd_sel) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_bank[r_fill_sel][r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_full     <= '0;
      r_last     <= '0;
      r_fill_sel <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_wr_ptr   <= '0;
      r_last_acc <= 1'b0;
    end else begin
      if (w_wr) begin
        if (w_wrap) begin
          r_wr_ptr           <= '0;
          r_fill_sel         <= ~r_fill_sel;
          r_last[r_fill_sel] <= r_last_acc | i_last;
          r_last_acc         <= 1'b0;
        end else begin
          r_wr_ptr   <= r_wr_ptr + AW'(1);
          r_last_acc <= r_last_acc | i_last;
        end
      end
      if (i_free) begin
        r_rd_sel <= ~r_rd_sel;
      end
      r_full <= (r_full & ~w_rel) | w_set;
    end
  end

  assign o_rd_full  = r_full[r_rd_sel];
  assign o_rd_last  = r_last[r_rd_sel];
  assign o_rd_data  = r_bank[r_rd_sel][i_rd_addr];
  assign o_overflow = w_drop;

endmodule

// File: rtl/dct_sequencer.sv
// Replays each buffered frame element N_COEF times to the DCT, with a one-cycle gap between frames.
// Optional feature: DCT_SEQ_OVERFLOW_CNT_EN adds overflow_cnt_o, a saturating dropped-element count.
module dct_sequencer
  import dct_pkg::*;
#(
  parameter int unsigned FRAME_LEN = dct_pkg::FRAME_LEN,
  parameter int unsigned N_COEF    = dct_pkg::N_COEF,
  parameter int unsigned I_BW      = dct_pkg::I_BW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dct_sequencer_if.slave  bus
`ifdef DCT_SEQ_OVERFLOW_CNT_EN
  ,
  output logic [7:0]      overflow_cnt_o
`endif
);

  localparam int unsigned EW = cnt_w(FRAME_LEN);
  localparam int unsigned CW = cnt_w(N_COEF);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_elem;
  logic [EW-1:0]   w_elem_nxt;
  logic [CW-1:0]   r_coef;
  logic [CW-1:0]   w_coef_nxt;
  logic            w_free;
  logic            w_clr;
  logic            w_rd_full;
  logic            w_rd_last;
  logic [I_BW-1:0] w_rd_data;
  logic            w_ovf;
  logic [I_BW-1:0] r_dct_data;
  logic            r_dct_valid;
  logic            r_dct_last;

  assign w_clr = rst_i || !bus.en_i;

  dct_frame_buffer #(
    .FRAME_LEN (FRAME_LEN),
    .I_BW      (I_BW)
  ) u_buf (
    .i_clk      (clk_i),
    .i_clr      (w_clr),
    .i_valid    (bus.valid_i),
    .i_data     (bus.data_i),
    .i_last     (bus.last_i),
    .i_free     (w_free),
    .i_rd_addr  (w_elem_nxt),
    .o_rd_full  (w_rd_full),
    .o_rd_last  (w_rd_last),
    .o_rd_data  (w_rd_data),
    .o_overflow (w_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_coef_nxt  = r_coef;
    w_free      = 1'b0;
    case (r_state)
      IDLE: begin
        w_elem_nxt = '0;
        w_coef_nxt = '0;
        if (w_rd_full) begin
          w_state_nxt = REPLAY;
        end
      end
      REPLAY: begin
        if (r_coef == CW'(N_COEF - 1)) begin
          w_coef_nxt = '0;
          if (r_elem == EW'(FRAME_LEN - 1)) begin
            w_elem_nxt  = '0;
            w_state_nxt = GAP;
            w_free      = 1'b1;
          end else begin
            w_elem_nxt = r_elem + EW'(1);
          end
        end else begin
          w_coef_nxt = r_coef + CW'(1);
        end
      end
      GAP: begin
        w_elem_nxt  = '0;
        w_coef_nxt  = '0;
        w_state_nxt = w_rd_full ? REPLAY : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_elem_nxt  = '0;
        w_coef_nxt  = '0;
      end
    endcase
  end

  // Outputs are registered from the next position, so the read address is w_elem_nxt.
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_state     <= IDLE;
      r_elem      <= '0;
      r_coef      <= '0;
      r_dct_valid <= 1'b0;
      r_dct_last  <= 1'b0;
      r_dct_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_elem      <= w_elem_nxt;
      r_coef      <= w_coef_nxt;
      r_dct_valid <= (w_state_nxt == REPLAY);
      r_dct_data  <= (w_state_nxt == REPLAY) ? w_rd_data : '0;
      r_dct_last  <= (w_state_nxt == REPLAY) && (w_elem_nxt == EW'(FRAME_LEN - 1)) && w_rd_last;
    end
  end

  assign bus.dct_data_o  = r_dct_data;
  assign bus.dct_valid_o = r_dct_valid;
  assign bus.dct_last_o  = r_dct_last;
  assign bus.dct_en_o    = bus.en_i;
  assign bus.overflow_o  = w_ovf;

`ifdef DCT_SEQ_OVERFLOW_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign overflow_cnt_o = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_dct_sequencer.sv
// Scoreboard bench for dct_sequencer: expected replay stream queued at stimulus time, checked per output cycle.
module tb_dct_sequencer;

  localparam int FL        = 32;
  localparam int NC        = 13;
  localparam int FRAME_CYC = 416;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_sequencer_if #(.I_BW(8)) bus ();

`ifdef DCT_SEQ_OVERFLOW_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  dct_sequencer #(
    .FRAME_LEN (FL),
    .N_COEF    (NC),
    .I_BW      (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DCT_SEQ_OVERFLOW_CNT_EN
    ,
    .overflow_cnt_o (ovf_cnt)
`endif
  );

  int       checks = 0;
  int       errors = 0;
  bit [8:0] q[$];
  bit [8:0] mon_e;
  int       run = 0;
  int       idle = 0;
  int       ovf_seen = 0;
  bit       fall_pend = 1'b0;
  bit       prev_valid = 1'b0;
  bit       mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops one expected {last,data} per valid cycle, checks frame length and gap.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.dct_valid_o) begin
        if (!prev_valid && fall_pend) begin
          check("gap_len", idle, 1);
          fall_pend = 1'b0;
        end
        check("q_nonempty_on_valid", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("data", bus.dct_data_o, mon_e[7:0]);
          check("last", bus.dct_last_o, mon_e[8]);
        end
        run++;
      end else begin
        check("data_zero_idle", bus.dct_data_o, 0);
        if (prev_valid) begin
          check("frame_len", run, FRAME_CYC);
          run       = 0;
          idle      = 0;
          fall_pend = (q.size() != 0);
        end
        idle++;
      end
      if (bus.overflow_o) ovf_seen++;
      prev_valid = bus.dct_valid_o;
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit l);
    @(posedge clk);
    #1;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.last_i  = l;
  endtask

  task automatic push_frame(input logic [7:0] base, input bit lastf);
    logic [7:0] d;
    for (int e = 0; e < FL; e++) begin
      d = base + 8'(e);
      for (int c = 0; c < NC; c++) q.push_back({lastf && (e == FL - 1), d});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || bus.dct_valid_o) && n < 3000) begin
      drive(0, 8'd0, 0);
      n++;
    end
    check("drain_timeout", n < 3000, 1);
    repeat (3) drive(0, 8'd0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base_ovf;
    int n;
    bus.en_i    = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.last_i  = 1'b0;
    rst         = 1'b1;
    repeat (3) drive(0, 8'd0, 0);
    @(negedge clk);
    check("rst_valid", bus.dct_valid_o, 0);
    check("rst_last", bus.dct_last_o, 0);
    check("rst_data", bus.dct_data_o, 0);
    check("rst_ovf", bus.overflow_o, 0);
    check("rst_en", bus.dct_en_o, 1);
    drive(0, 8'd0, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single frame 0..31, last with element 31; valid rises one cycle after the full flag.
    push_frame(8'd0, 1);
    for (int i = 0; i < FL; i++) drive(1, 8'(i), i == FL - 1);
    drive(0, 8'd0, 0);
    @(negedge clk);
    check("lat_full_cycle", bus.dct_valid_o, 0);
    @(negedge clk);
    check("lat_replay_start", bus.dct_valid_o, 1);
    wait_drain();

    // Two frames back to back: one-cycle gap, no overflow.
    base_ovf = ovf_seen;
    push_frame(8'd100, 0);
    push_frame(8'd132, 1);
    for (int i = 0; i < 2 * FL; i++) drive(1, 8'(100 + i), i == 2 * FL - 1);
    wait_drain();
    check("b2b_ovf", ovf_seen - base_ovf, 0);

    // 96 elements: last 32 dropped.
    base_ovf = ovf_seen;
    push_frame(8'd0, 0);
    push_frame(8'd32, 0);
    for (int i = 0; i < 3 * FL; i++) drive(1, 8'(i), 0);
    wait_drain();
    check("drop_ovf", ovf_seen - base_ovf, 32);
`ifdef DCT_SEQ_OVERFLOW_CNT_EN
    check("drop_ovf_cnt", ovf_cnt, 32);
`endif

    // Frame B completes on the cycle frame A is released; last_i mid-frame marks B.
    base_ovf = ovf_seen;
    push_frame(8'd10, 0);
    push_frame(8'd60, 1);
    for (int c = 0; c < 450; c++) begin
      if (c < FL)                drive(1, 8'(10 + c), 0);
      else if (c < 2 * FL - 1)   drive(1, 8'(60 + c - FL), (c - FL) == 3);
      else if (c == 448)         drive(1, 8'(60 + FL - 1), 0);
      else                       drive(0, 8'd0, 0);
    end
    wait_drain();
    check("swap_ovf", ovf_seen - base_ovf, 0);

    // Reset after 200 replay cycles abandons the frame.
    push_frame(8'd200, 0);
    for (int i = 0; i < FL; i++) drive(1, 8'(200 + i), 0);
    n = 0;
    while (run < 200 && n < 1000) begin
      drive(0, 8'd0, 0);
      n++;
    end
    check("run_to_200", run, 200);
    mon_en = 1'b0;
    rst    = 1'b1;
    drive(0, 8'd0, 0);
    @(negedge clk);
    check("rst_mid_valid", bus.dct_valid_o, 0);
    check("rst_mid_data", bus.dct_data_o, 0);
    drive(0, 8'd0, 0);
    rst = 1'b0;
    q.delete();
    run        = 0;
    idle       = 0;
    prev_valid = 1'b0;
    fall_pend  = 1'b0;
    mon_en     = 1'b1;
    push_frame(8'd7, 0);
    for (int i = 0; i < FL; i++) drive(1, 8'(7 + i), 0);
    wait_drain();

    // en_i low for one cycle at wr_ptr=10 discards the partial frame.
    for (int i = 0; i < 10; i++) drive(1, 8'(50 + i), 0);
    drive(0, 8'd0, 0);
    bus.en_i = 1'b0;
    @(negedge clk);
    check("dct_en_low", bus.dct_en_o, 0);
    drive(0, 8'd0, 0);
    bus.en_i = 1'b1;
    @(negedge clk);
    check("dct_en_high", bus.dct_en_o, 1);
`ifdef DCT_SEQ_OVERFLOW_CNT_EN
    check("en_clr_ovf_cnt", ovf_cnt, 0);
`endif
    push_frame(8'd90, 0);
    for (int i = 0; i < FL; i++) drive(1, 8'(90 + i), 0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
